// File: rtl/counter_arbiter.sv
// Round-robin owner of one shared up-counter: each grant gets a one-cycle
// clear, SWEEPS full sweeps of counting, then a done pulse to its owner.
module counter_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 6,
   parameter int SWEEPS  = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       hold,
   input  logic                       cnt_cout,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic [NUM_REQ-1:0]         done,
   output logic                       busy,
   output logic                       cnt_clear,
   output logic                       cnt_enable
);
   localparam int ID_W = $clog2(NUM_REQ);
   localparam int SW_W = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] pick;
   logic [ID_W-1:0] cand;
   logic [SW_W-1:0] sweep;
   logic            found;
   logic            hit;
   logic            abort;
   logic            wrap;
   logic            last_sweep;

   // The counter lives outside; reject shapes the sequencing cannot serve.
   if (NUM_REQ < 2 || CNT_W < 1 || SWEEPS < 1) begin : g_param_check
      $error("counter_arbiter: needs NUM_REQ>=2, CNT_W>=1, SWEEPS>=1");
   end

   function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
      onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
   endfunction

   // First set request searching from ptr+1 around to ptr itself
   always_comb begin
      found = 1'b0;
      hit   = 1'b0;
      pick  = ptr;
      cand  = ptr;
      for (int i = 1; i < NUM_REQ; i++) begin
         cand  = (ptr >= ID_W'(NUM_REQ - i)) ? (ptr - ID_W'(NUM_REQ - i)) : (ptr + ID_W'(i));
         hit   = !found && req[cand];
         pick  = hit ? cand : pick;
         found = found || hit;
      end
      hit   = !found && req[ptr];
      pick  = hit ? ptr : pick;
      found = found || hit;
   end

   assign abort      = !req[grant_id];
   assign wrap       = cnt_cout && cnt_enable;
   assign last_sweep = (sweep == SW_W'(SWEEPS - 1));
   assign busy       = (state != S_IDLE);
   assign cnt_clear  = (state == S_CLEAR);
   assign cnt_enable = (state == S_RUN) && !hold;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state decision; a dropped request outranks a simultaneous final wrap
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (found) state_next = S_CLEAR;
            else       state_next = S_IDLE;
         end
         S_CLEAR: begin
            if (abort) state_next = S_IDLE;
            else       state_next = S_RUN;
         end
         S_RUN: begin
            if (abort)                   state_next = S_IDLE;
            else if (wrap && last_sweep) state_next = S_DONE;
            else                         state_next = S_RUN;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Owner, round-robin pointer, sweep count and done pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grant    <= '0;
         grant_id <= '0;
         ptr      <= ID_W'(NUM_REQ - 1);
         sweep    <= '0;
         done     <= '0;
      end else begin
         done <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant    <= onehot(pick);
                  grant_id <= pick;
               end
            end
            S_CLEAR: begin
               sweep <= '0;
               if (abort) begin
                  grant <= '0;
                  ptr   <= grant_id;
               end
            end
            S_RUN: begin
               if (abort) begin
                  grant <= '0;
                  ptr   <= grant_id;
               end else if (wrap) begin
                  if (last_sweep) begin
                     grant <= '0;
                     done  <= onehot(grant_id);
                  end else begin
                     sweep <= sweep + SW_W'(1);
                  end
               end
            end
            S_DONE:  ptr <= grant_id;
            default: grant <= '0;
         endcase
      end
   end
endmodule
